cache_core_wb: RTL and testbench
================================

Name: cache_core_wb

Overview:
- Parametrised successor of the fixed 4-channel cache: N-way set-associative, write-back/write-allocate cache core with per-line valid and dirty bits and a per-set FIFO replacement pointer.
- Sits between the CPU interface (cache_clk domain side) and the RAM interface.
- Transfers whole lines as LINE_WORDS-word bursts.
- Evicts only dirty victims.
- Provides saturating hit/miss statistics counters.

Parameters:
- TAG_SIZE, 5, tag bits.
- INDEX_SIZE, 6, set index bits; SETS = 2^INDEX_SIZE.
- OFFSET_SIZE, 3, byte offset bits within a line; must be >= 2. LINE_WORDS = 2^(OFFSET_SIZE-2), derived.
- WAYS, 4, associativity (power of two, >= 2).
- WAY_WIDTH, 2, log2(WAYS).
- WORD_SIZE, 32, data word width (fixed at 32 by byte enables).
- CNT_WIDTH, 16, statistics counter width.

Ports:
- cache_clk  in  1  clock; all logic on the rising edge.
- cache_not_reset  in  1  asynchronous, active-low reset.
- sys_addr  in  TAG_SIZE+INDEX_SIZE+OFFSET_SIZE  byte address: {tag, index, offset}; bits [1:0] ignored.
- sys_wdata  in  WORD_SIZE  write data.
- sys_rd  in  1  read request, level, held until sys_ack.
- sys_wr  in  1  write request, level, held until sys_ack.
- sys_bval  in  4  byte enables for writes; bit i enables byte i.
- sys_rdata  out  WORD_SIZE  read data, valid in the sys_ack cycle.
- sys_ack  out  1  one-cycle completion pulse.
- ram_addr  out  TAG_SIZE+INDEX_SIZE  line address {tag, index}.
- ram_wdata  out  WORD_SIZE  current write-back word.
- ram_avalid  out  1  burst request, held for the whole burst.
- ram_rnw  out  1  1 = fill (read), 0 = write-back.
- ram_rdata  in  WORD_SIZE  fill word, valid when ram_rack = 1.
- ram_rack  in  1  per-word acknowledge.
- hit_count  out  CNT_WIDTH  saturating count of lookups that hit.
- miss_count  out  CNT_WIDTH  saturating count of lookups that missed.

Behaviour:
- Reset (async):
  - All valid and dirty bits, FIFO pointers and state cleared.
  - All outputs 0; counters 0.
  - Reset mid-burst aborts the burst: ram_avalid falls immediately and no partial line is marked valid.
- States: IDLE, LOOKUP, RESP, WBACK, FILL.
- IDLE:
  - If sys_rd or sys_wr is high, register address, wdata, bval and op, then go to LOOKUP.
  - sys_rd and sys_wr both high is treated as a write.
- LOOKUP (one cycle): compare the tag against all WAYS ways of the set.
  - Hit, read: select the word at offset[OFFSET_SIZE-1:2] into sys_rdata.
  - Hit, write: merge enabled bytes into the line and set dirty.
  - Hit, read or write: hit_count++ (saturate), go to RESP.
  - Miss: miss_count++ (saturate), choose victim.
    - Victim is the lowest-numbered invalid way; if all ways are valid, the way at the set's FIFO pointer.
    - If the victim is valid and dirty: WBACK. Otherwise: FILL.
- RESP: sys_ack = 1 for exactly one cycle, then IDLE. The CPU must drop its request in the cycle after sys_ack; a request still high in IDLE starts a new access.
- Latency, hit: request sampled at edge 0, sys_ack high after edge 2. Request to ack is 2 cycles.
- WBACK:
  - ram_avalid = 1, ram_rnw = 0, ram_addr = {victim tag, index}.
  - ram_wdata = victim word k, k from 0; k advances on each ram_rack.
  - After the LINE_WORDS-th rack: clear dirty, drop ram_avalid for at least one cycle, go to FILL.
- FILL:
  - ram_avalid = 1, ram_rnw = 1, ram_addr = {request tag, index}.
  - Each ram_rack writes ram_rdata into word k of the victim way.
  - After the last rack: set valid, tag and dirty = 0 for that way.
  - If the victim came from the FIFO pointer, increment the pointer (mod WAYS).
  - Return to LOOKUP; the retry hits and is counted as a hit.
- Miss latency: 2 + fill burst + 1, plus write-back burst + 1 if dirty.
- ram_rack while ram_avalid = 0 is ignored.
- ram_rdata is sampled only when ram_rack = 1.
- Counters saturate at all-ones and never wrap.
- Storage: tag/valid/dirty/data arrays are internal registers, WAYS x SETS; data lines are LINE_WORDS*WORD_SIZE bits.

Test Plan:
- Reset, then read 0x0010 (defaults) -> miss.
  - FILL burst of 2 words at ram_addr 0x002, no WBACK.
  - sys_ack with the RAM word for offset 0.
  - miss_count = 1, hit_count = 1.
- Write 0xAABBCCDD with bval 4'b0101 to a resident word 0x11223344, then read it back.
  - Both accesses take 2-cycle latency.
  - Read returns 0x11BB33DD; hit_count increments by 2.
- Fill all 4 ways of set 0, then access a 5th tag.
  - Way 0 replaced, FIFO pointer becomes 1.
  - No WBACK, because all lines are clean.
- Dirty way 0 of set 0, then force its eviction.
  - WBACK burst (ram_rnw = 0) carries the dirty line words at the old tag's address.
  - FILL follows.
  - A later read of the old address misses and refills with the written data.
- Assert cache_not_reset = 0 during the second word of a FILL.
  - ram_avalid drops immediately.
  - A subsequent read of the same line misses (valid cleared).
- Drive 2^CNT_WIDTH+3 hits (CNT_WIDTH = 4 build) -> hit_count holds at 0xF.
- Assert sys_rd and sys_wr together -> access performed as a write, dirty set.

Source files
------------

// File: rtl/cache_core_wb.sv
// N-way set-associative write-back/write-allocate cache core with per-set FIFO
// replacement, whole-line RAM bursts and saturating hit/miss statistics.
module cache_core_wb #(
   parameter int TAG_SIZE    = 5,
   parameter int INDEX_SIZE  = 6,
   parameter int OFFSET_SIZE = 3,
   parameter int WAYS        = 4,
   parameter int WAY_WIDTH   = 2,
   parameter int WORD_SIZE   = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                                       cache_clk,
   input  logic                                       cache_not_reset,
   input  logic [TAG_SIZE+INDEX_SIZE+OFFSET_SIZE-1:0] sys_addr,
   input  logic [WORD_SIZE-1:0]                       sys_wdata,
   input  logic                                       sys_rd,
   input  logic                                       sys_wr,
   input  logic [3:0]                                 sys_bval,
   output logic [WORD_SIZE-1:0]                       sys_rdata,
   output logic                                       sys_ack,
   output logic [TAG_SIZE+INDEX_SIZE-1:0]             ram_addr,
   output logic [WORD_SIZE-1:0]                       ram_wdata,
   output logic                                       ram_avalid,
   output logic                                       ram_rnw,
   input  logic [WORD_SIZE-1:0]                       ram_rdata,
   input  logic                                       ram_rack,
   output logic [CNT_WIDTH-1:0]                       hit_count,
   output logic [CNT_WIDTH-1:0]                       miss_count,
   output logic [2:0]                                 dbg_state
);

   // Handshakes: sys_rd/sys_wr are level requests held until the single-cycle
   // sys_ack; ram_avalid is held for a whole burst and every ram_rack seen while
   // ram_avalid is high moves exactly one word (racks with ram_avalid low are ignored).

   localparam int SETS       = 1 << INDEX_SIZE;
   localparam int LINE_WORDS = 1 << (OFFSET_SIZE - 2);
   localparam int WIDX_W     = (OFFSET_SIZE > 2) ? OFFSET_SIZE - 2 : 1;
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_RESP   = 3'd2,
      S_WBACK  = 3'd3,
      S_FILL   = 3'd4
   } state_t;

   state_t state;

   logic [TAG_SIZE-1:0]   req_tag;
   logic [INDEX_SIZE-1:0] req_index;
   logic [WIDX_W-1:0]     req_word;
   logic [WORD_SIZE-1:0]  req_wdata;
   logic [3:0]            req_bval;
   logic                  req_write;
   logic [WAY_WIDTH-1:0]  victim_way;
   logic                  victim_fifo;
   logic [WIDX_W-1:0]     word_k;
   logic [WIDX_W-1:0]     next_k;

   logic [WAYS-1:0]      valid_mem [SETS];
   logic [WAYS-1:0]      dirty_mem [SETS];
   logic [WAY_WIDTH-1:0] fifo_ptr  [SETS];
   logic [TAG_SIZE-1:0]  tag_mem   [WAYS][SETS];
   logic [WORD_SIZE-1:0] data_mem  [WAYS][SETS][LINE_WORDS];

   logic                 hit;
   logic [WAY_WIDTH-1:0] hit_way;
   logic                 free_found;
   logic [WAY_WIDTH-1:0] free_way;
   logic [WAY_WIDTH-1:0] victim;
   logic [WORD_SIZE-1:0] hit_word;
   logic [WORD_SIZE-1:0] merged_word;
   logic                 fill_we;
   logic                 fill_done;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^sys_addr[1:0];
   assign dbg_state        = state;
   assign next_k           = word_k + WIDX_W'(1);

   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_mem[req_index][w] && (tag_mem[w][req_index] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_WIDTH'(w);
         end
         if (!free_found && !valid_mem[req_index][w]) begin
            free_found = 1'b1;
            free_way   = WAY_WIDTH'(w);
         end
      end
   end

   // Invalid ways are used lowest-first; once the set is full the FIFO pointer picks.
   assign victim   = free_found ? free_way : fifo_ptr[req_index];
   assign hit_word = data_mem[hit_way][req_index][req_word];

   always_comb begin
      merged_word = hit_word;
      for (int b = 0; b < 4; b++) begin
         if (req_bval[b]) merged_word[8*b +: 8] = req_wdata[8*b +: 8];
      end
   end

   assign fill_we   = (state == S_FILL) && ram_avalid && ram_rack;
   assign fill_done = fill_we && (word_k == LAST_WORD);

   // Tag and data storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge cache_clk) begin
      if ((state == S_LOOKUP) && hit && req_write)
         data_mem[hit_way][req_index][req_word] <= merged_word;
      if (fill_we)
         data_mem[victim_way][req_index][word_k] <= ram_rdata;
      if (fill_done)
         tag_mem[victim_way][req_index] <= req_tag;
   end

   always_ff @(posedge cache_clk or negedge cache_not_reset) begin
      if (!cache_not_reset) begin
         state       <= S_IDLE;
         req_tag     <= '0;
         req_index   <= '0;
         req_word    <= '0;
         req_wdata   <= '0;
         req_bval    <= '0;
         req_write   <= 1'b0;
         victim_way  <= '0;
         victim_fifo <= 1'b0;
         word_k      <= '0;
         sys_rdata   <= '0;
         sys_ack     <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_avalid  <= 1'b0;
         ram_rnw     <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
            fifo_ptr[s]  <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               sys_ack <= 1'b0;
               if (sys_rd || sys_wr) begin
                  req_tag   <= sys_addr[TAG_SIZE+INDEX_SIZE+OFFSET_SIZE-1 -: TAG_SIZE];
                  req_index <= sys_addr[OFFSET_SIZE +: INDEX_SIZE];
                  req_word  <= (LINE_WORDS == 1) ? '0 : sys_addr[2 +: WIDX_W];
                  req_wdata <= sys_wdata;
                  req_bval  <= sys_bval;
                  req_write <= sys_wr;
                  state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                  if (req_write) dirty_mem[req_index][hit_way] <= 1'b1;
                  else           sys_rdata <= hit_word;
                  state <= S_RESP;
               end else begin
                  if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                  victim_way  <= victim;
                  victim_fifo <= !free_found;
                  word_k      <= '0;
                  ram_avalid  <= 1'b1;
                  if (valid_mem[req_index][victim] && dirty_mem[req_index][victim]) begin
                     ram_rnw   <= 1'b0;
                     ram_addr  <= {tag_mem[victim][req_index], req_index};
                     ram_wdata <= data_mem[victim][req_index][0];
                     state     <= S_WBACK;
                  end else begin
                     ram_rnw  <= 1'b1;
                     ram_addr <= {req_tag, req_index};
                     state    <= S_FILL;
                  end
               end
            end
            S_RESP: begin
               sys_ack <= 1'b1;
               state   <= S_IDLE;
            end
            S_WBACK: begin
               if (ram_avalid && ram_rack) begin
                  if (word_k == LAST_WORD) begin
                     dirty_mem[req_index][victim_way] <= 1'b0;
                     ram_avalid <= 1'b0;
                     word_k     <= '0;
                     state      <= S_FILL;
                  end else begin
                     word_k    <= next_k;
                     ram_wdata <= data_mem[victim_way][req_index][next_k];
                  end
               end
            end
            S_FILL: begin
               // Arriving from a write-back, ram_avalid is low for one cycle first.
               if (!ram_avalid) begin
                  ram_avalid <= 1'b1;
                  ram_rnw    <= 1'b1;
                  ram_addr   <= {req_tag, req_index};
               end else if (ram_rack) begin
                  if (word_k == LAST_WORD) begin
                     valid_mem[req_index][victim_way] <= 1'b1;
                     dirty_mem[req_index][victim_way] <= 1'b0;
                     if (victim_fifo) fifo_ptr[req_index] <= fifo_ptr[req_index] + WAY_WIDTH'(1);
                     ram_avalid <= 1'b0;
                     word_k     <= '0;
                     state      <= S_LOOKUP;
                  end else begin
                     word_k <= next_k;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_core_wb.sv
// Randomised bench for cache_core_wb: a RAM responder plus a reference model that
// tracks resident tags per set as insertion-ordered queues and a flat memory image.
module tb_cache_core_wb;

   localparam int CW = 4;

   logic          cache_clk;
   logic          cache_not_reset;
   logic [13:0]   sys_addr;
   logic [31:0]   sys_wdata;
   logic          sys_rd;
   logic          sys_wr;
   logic [3:0]    sys_bval;
   logic [31:0]   sys_rdata;
   logic          sys_ack;
   logic [10:0]   ram_addr;
   logic [31:0]   ram_wdata;
   logic          ram_avalid;
   logic          ram_rnw;
   logic [31:0]   ram_rdata = '0;
   logic          ram_rack = 1'b0;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;
   logic [2:0]    dbg_state;

   cache_core_wb #(.CNT_WIDTH(CW)) dut (
      .cache_clk(cache_clk), .cache_not_reset(cache_not_reset),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_rd(sys_rd), .sys_wr(sys_wr),
      .sys_bval(sys_bval), .sys_rdata(sys_rdata), .sys_ack(sys_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_avalid(ram_avalid), .ram_rnw(ram_rnw),
      .ram_rdata(ram_rdata), .ram_rack(ram_rack),
      .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial cache_clk = 1'b0;
   always #5 cache_clk = ~cache_clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ram_mem [4096];
   logic [31:0] ref_mem [4096];
   int          res_q [64][$];
   bit          dirty_m [64][32];
   logic [CW-1:0] hit_m  = '0;
   logic [CW-1:0] miss_m = '0;
   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];

   int ram_delay_max = 0;
   int rack_limit    = 2;
   bit stray_en      = 1'b0;
   int rk            = 0;
   bit av_prev       = 1'b0;

   logic [31:0] last_rdata;
   int          last_lat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] mk_addr(input int tag, input int set, input int word);
      logic [13:0] a;
      a = '0;
      a[13:9] = tag[4:0];
      a[8:3]  = set[5:0];
      a[2]    = word[0];
      return a;
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   // ---------------- RAM responder and burst monitor ----------------
   always @(negedge cache_clk) begin
      if (ram_avalid && !av_prev) begin
         obs_q.push_back({ram_rnw, ram_addr});
         rk = 0;
      end
      av_prev   = ram_avalid;
      ram_rack  = 1'b0;
      ram_rdata = $urandom;
      if (ram_avalid) begin
         if (rk < rack_limit && $urandom_range(0, ram_delay_max) == 0) begin
            ram_rack = 1'b1;
            if (ram_rnw) ram_rdata = ram_mem[{ram_addr, rk[0]}];
            else         ram_mem[{ram_addr, rk[0]}] = ram_wdata;
            rk++;
         end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
         ram_rack = 1'b1;
      end
   end

   // ---------------- reference model ----------------
   task automatic model_access(input bit wr, input logic [13:0] addr, input logic [31:0] wdata,
                               input logic [3:0] bval, output bit was_hit, output bit had_wb,
                               output logic [31:0] rexp);
      int t, s, v;
      logic [11:0] wa;
      t = int'(addr[13:9]);
      s = int'(addr[8:3]);
      wa = addr[13:2];
      was_hit = 1'b0;
      had_wb  = 1'b0;
      for (int i = 0; i < res_q[s].size(); i++) if (res_q[s][i] == t) was_hit = 1'b1;
      if (!was_hit) begin
         if (res_q[s].size() == 4) begin
            v = res_q[s].pop_front();
            if (dirty_m[s][v]) begin
               exp_q.push_back({1'b0, v[4:0], s[5:0]});
               dirty_m[s][v] = 1'b0;
               had_wb = 1'b1;
            end
         end
         exp_q.push_back({1'b1, t[4:0], s[5:0]});
         res_q[s].push_back(t);
         miss_m = sat_inc(miss_m);
      end
      hit_m = sat_inc(hit_m);
      if (wr) begin
         for (int b = 0; b < 4; b++) if (bval[b]) ref_mem[wa][8*b +: 8] = wdata[8*b +: 8];
         dirty_m[s][t] = 1'b1;
      end
      rexp = ref_mem[wa];
   endtask

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         res_q[s].delete();
         for (int t = 0; t < 32; t++) dirty_m[s][t] = 1'b0;
      end
      hit_m  = '0;
      miss_m = '0;
      ref_mem = ram_mem;
   endtask

   // ---------------- driver ----------------
   task automatic do_access(input bit rd, input bit wr, input logic [13:0] addr,
                            input logic [31:0] wdata, input logic [3:0] bval);
      bit was_hit, had_wb, got;
      logic [31:0] rexp;
      int cycles;
      obs_q.delete();
      exp_q.delete();
      model_access(wr, addr, wdata, bval, was_hit, had_wb, rexp);
      @(negedge cache_clk);
      sys_addr = addr; sys_wdata = wdata; sys_bval = bval; sys_rd = rd; sys_wr = wr;
      cycles = 0;
      got = 1'b0;
      while (!got && cycles < 400) begin
         @(negedge cache_clk);
         cycles++;
         got = sys_ack;
      end
      check("ack_seen", 64'(got), 64'(1));
      last_rdata = sys_rdata;
      last_lat   = cycles - 1;
      if (got && !wr) check("rdata", 64'(sys_rdata), 64'(rexp));
      if (got && was_hit) check("hit_latency", 64'(last_lat), 64'(2));
      else if (got && ram_delay_max == 0) check("miss_latency", 64'(last_lat), 64'(had_wb ? 8 : 5));
      sys_rd = 1'b0;
      sys_wr = 1'b0;
      @(negedge cache_clk);
      check("ack_pulse", 64'(sys_ack), 64'(0));
      check("burst_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check("burst_addr", 64'(obs_q[i]), 64'(exp_q[i]));
      check("hit_count", 64'(hit_count), 64'(hit_m));
      check("miss_count", 64'(miss_count), 64'(miss_m));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      cache_not_reset = 1'b0;
      sys_addr = '0; sys_wdata = '0; sys_rd = 1'b0; sys_wr = 1'b0; sys_bval = '0;
      for (int i = 0; i < 4096; i++) ram_mem[i] = $urandom;
      ram_mem[4] = 32'h1122_3344;
      model_reset();
      repeat (3) @(negedge cache_clk);
      check("rst_ack", 64'(sys_ack), 64'(0));
      check("rst_avalid", 64'(ram_avalid), 64'(0));
      check("rst_hits", 64'(hit_count), 64'(0));
      check("rst_misses", 64'(miss_count), 64'(0));
      check("rst_rdata", 64'(sys_rdata), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(0));
      cache_not_reset = 1'b1;

      // cold read miss, then write-merge and read back
      do_access(1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
      check("cold_rdata", 64'(last_rdata), 64'h1122_3344);
      do_access(1'b0, 1'b1, 14'h0010, 32'hAABB_CCDD, 4'b0101);
      do_access(1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
      check("merge_rdata", 64'(last_rdata), 64'h11BB_33DD);

      // fill set 0, then a fifth tag replaces the oldest
      for (int t = 1; t <= 5; t++) do_access(1'b1, 1'b0, mk_addr(t, 0, 0), 32'h0, 4'h0);
      do_access(1'b1, 1'b0, mk_addr(2, 0, 0), 32'h0, 4'h0);
      do_access(1'b1, 1'b0, mk_addr(1, 0, 0), 32'h0, 4'h0);

      // dirty the oldest line, force its eviction, read it back from RAM
      do_access(1'b0, 1'b1, mk_addr(3, 0, 1), 32'hCAFE_0001, 4'hF);
      do_access(1'b1, 1'b0, mk_addr(6, 0, 0), 32'h0, 4'h0);
      do_access(1'b1, 1'b0, mk_addr(3, 0, 1), 32'h0, 4'h0);
      check("wb_refill", 64'(last_rdata), 64'hCAFE_0001);

      // read and write together behave as a write that leaves the line dirty
      do_access(1'b1, 1'b1, mk_addr(0, 5, 0), 32'h5A5A_1234, 4'hF);
      for (int t = 1; t <= 4; t++) do_access(1'b1, 1'b0, mk_addr(t, 5, 0), 32'h0, 4'h0);
      do_access(1'b1, 1'b0, mk_addr(0, 5, 0), 32'h0, 4'h0);
      check("rdwr_data", 64'(last_rdata), 64'h5A5A_1234);

      // random traffic with stalling RAM and stray acknowledges
      ram_delay_max = 2;
      stray_en      = 1'b1;
      for (int n = 0; n < 200; n++) begin
         int op;
         op = $urandom_range(0, 9);
         do_access(op != 9 && op < 5 ? 1'b1 : (op == 9), op >= 5,
                   mk_addr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1)),
                   $urandom, 4'($urandom_range(0, 15)));
      end
      ram_delay_max = 0;
      stray_en      = 1'b0;

      // reset during the second word of a fill
      rack_limit = 1;
      @(negedge cache_clk);
      sys_addr = mk_addr(3, 40, 1); sys_rd = 1'b1;
      repeat (4) @(negedge cache_clk);
      check("mid_fill_avalid", 64'(ram_avalid), 64'(1));
      check("mid_fill_rnw", 64'(ram_rnw), 64'(1));
      #1 cache_not_reset = 1'b0;
      #1;
      check("abort_avalid", 64'(ram_avalid), 64'(0));
      check("abort_hits", 64'(hit_count), 64'(0));
      check("abort_misses", 64'(miss_count), 64'(0));
      check("abort_state", 64'(dbg_state), 64'(0));
      sys_rd = 1'b0;
      rack_limit = 2;
      model_reset();
      @(negedge cache_clk);
      cache_not_reset = 1'b1;
      do_access(1'b1, 1'b0, mk_addr(3, 40, 1), 32'h0, 4'h0);
      check("post_reset_miss", 64'(miss_count), 64'(1));

      // hit counter saturation
      do_access(1'b1, 1'b0, mk_addr(1, 41, 0), 32'h0, 4'h0);
      for (int n = 0; n < (1 << CW) + 3; n++) do_access(1'b1, 1'b0, mk_addr(1, 41, 0), 32'h0, 4'h0);
      check("hit_saturated", 64'(hit_count), 64'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
